// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width, and the
// mid-bit sampling offset. Used by both uart_rx and uart_tx.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // Count at which the start bit is re-checked, i.e. its centre.
  function automatic int half_bit(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle. The master modport is the receiver itself;
// the slave modport is the line driver / byte consumer. UART_RX_PARITY_EN adds the parity error strobe.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 i_RX_Serial;
  logic                 o_RX_DV;
  logic [DATA_BITS-1:0] o_RX_Byte;
  logic                 o_RX_Active;
  logic                 o_RX_Frame_Err;
`ifdef UART_RX_PARITY_EN
  logic                 o_RX_Parity_Err;
`endif

  modport master (
    input  i_RX_Serial,
`ifdef UART_RX_PARITY_EN
    output o_RX_Parity_Err,
`endif
    output o_RX_DV, o_RX_Byte, o_RX_Active, o_RX_Frame_Err
  );

  modport slave (
    output i_RX_Serial,
`ifdef UART_RX_PARITY_EN
    input  o_RX_Parity_Err,
`endif
    input  o_RX_DV, o_RX_Byte, o_RX_Active, o_RX_Frame_Err
  );

endinterface

// File: rtl/uart_sync.sv
// Flop-chain synchroniser for the asynchronous serial line. Resets to 1 so a
// reset never looks like a start edge.
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '1;
    else     ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit, checks start/stop framing, and
// strobes each good byte. Define UART_RX_PARITY_EN for an even-parity bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int SYNC_STAGES  = 2
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(half_bit(CLKS_PER_BIT));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t            state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.i_RX_Serial),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      clk_cnt            <= '0;
      bit_idx            <= '0;
      shift              <= '0;
      bus.o_RX_DV        <= 1'b0;
      bus.o_RX_Byte      <= '0;
      bus.o_RX_Active    <= 1'b0;
      bus.o_RX_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad             <= 1'b0;
      bus.o_RX_Parity_Err <= 1'b0;
`endif
    end else begin
      bus.o_RX_DV        <= 1'b0;
      bus.o_RX_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.o_RX_Parity_Err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_s) begin
            state           <= START;
            bus.o_RX_Active <= 1'b1;
          end
        end

        // Re-check at the start-bit centre to reject short glitches.
        START: begin
          if (clk_cnt == CNT_HALF) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state           <= IDLE;
              bus.o_RX_Active <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt        <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            par_bad <= (rx_s != ^shift);
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif

        // Leaving from mid stop bit lets a back-to-back start edge be caught.
        STOP: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              state           <= IDLE;
              bus.o_RX_Active <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                bus.o_RX_Parity_Err <= 1'b1;
              end else begin
                bus.o_RX_Byte <= shift;
                bus.o_RX_DV   <= 1'b1;
              end
`else
              bus.o_RX_Byte <= shift;
              bus.o_RX_DV   <= 1'b1;
`endif
            end else begin
              bus.o_RX_Frame_Err <= 1'b1;
              state              <= BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        // A line held low after a bad stop bit must not restart framing.
        BREAK: begin
          clk_cnt <= '0;
          if (rx_s) begin
            state           <= IDLE;
            bus.o_RX_Active <= 1'b0;
          end
        end

        default: begin
          state           <= IDLE;
          clk_cnt         <= '0;
          bus.o_RX_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven bit by bit, expected
// bytes go to a scoreboard queue and are compared as the receiver strobes them.
module tb_uart_rx;

  localparam int C  = 8;
  localparam int SS = 2;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 76 + C + SS + 1;
`else
  localparam int LAT = 76 + SS + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(C), .SYNC_STAGES(SS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int cyc    = 0;
  int dv_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic [7:0] last_byte;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every DV strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_RX_DV && bus.o_RX_Frame_Err) begin
        checks++; errors++;
        $display("FAIL strobe_overlap: dv=1 frame_err=1, required never both");
      end
      if (bus.o_RX_DV) begin
        dv_cnt++;
        dv_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_dv: got byte %h, required no strobe", bus.o_RX_Byte);
        end else begin
          exp_b = exp_q.pop_front();
          if (bus.o_RX_Byte !== exp_b) begin
            errors++;
            $display("FAIL rx_byte: got %h required %h", bus.o_RX_Byte, exp_b);
          end
        end
      end
      if (bus.o_RX_Frame_Err) fe_cnt++;
`ifdef UART_RX_PARITY_EN
      if (bus.o_RX_Parity_Err) pe_cnt++;
`endif
    end
  end

  task automatic drive(input logic b);
    bus.i_RX_Serial = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.i_RX_Serial = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    drive(1'b0);
    for (int i = 0; i < 8; i++) drive(d[i]);
`ifdef UART_RX_PARITY_EN
    drive(par);
`else
    if (par) begin end
`endif
    drive(stop);
  endtask

  task automatic test_reset;
    checks++;
    if ({bus.o_RX_DV, bus.o_RX_Byte, bus.o_RX_Active, bus.o_RX_Frame_Err} !== 11'h0) begin
      errors++;
      $display("FAIL reset_outputs: got dv=%b byte=%h act=%b fe=%b required all 0",
               bus.o_RX_DV, bus.o_RX_Byte, bus.o_RX_Active, bus.o_RX_Frame_Err);
    end
    rst = 1'b0;
    idle(2 * C);
    checks++;
    if (bus.o_RX_Active !== 1'b0 || dv_cnt != 0) begin
      errors++;
      $display("FAIL reset_idle: got act=%b dv_cnt=%0d required 0 0", bus.o_RX_Active, dv_cnt);
    end
  endtask

  task automatic test_basic;
    int n0, t0;
    n0 = dv_cnt;
    t0 = cyc;
    exp_q.push_back(8'hA5); last_byte = 8'hA5;
    send_frame(8'hA5, ^8'hA5, 1'b1);
    idle(2 * C);
    checks++;
    if (dv_cnt != n0 + 1) begin
      errors++; $display("FAIL basic_dv_count: got %0d required %0d", dv_cnt - n0, 1);
    end
    checks++;
    if (dv_cyc - t0 != LAT) begin
      errors++; $display("FAIL basic_latency: got %0d required %0d", dv_cyc - t0, LAT);
    end
    checks++;
    if (bus.o_RX_Active !== 1'b0 || bus.o_RX_Byte !== 8'hA5) begin
      errors++;
      $display("FAIL basic_after: got act=%b byte=%h required 0 a5", bus.o_RX_Active, bus.o_RX_Byte);
    end
  endtask

  task automatic test_glitch;
    int n0, f0;
    n0 = dv_cnt; f0 = fe_cnt;
    bus.i_RX_Serial = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(3 * C);
    checks++;
    if (dv_cnt != n0 || fe_cnt != f0) begin
      errors++; $display("FAIL glitch_strobes: got dv=%0d fe=%0d required 0 0", dv_cnt - n0, fe_cnt - f0);
    end
    checks++;
    if (bus.o_RX_Byte !== last_byte || bus.o_RX_Active !== 1'b0) begin
      errors++;
      $display("FAIL glitch_state: got byte=%h act=%b required %h 0", bus.o_RX_Byte, bus.o_RX_Active, last_byte);
    end
  endtask

  task automatic test_frame_err;
    int n0, f0;
    n0 = dv_cnt; f0 = fe_cnt;
    send_frame(8'h3C, ^8'h3C, 1'b0);
    bus.i_RX_Serial = 1'b0;
    repeat (20 * C) @(posedge clk);
    #1;
    checks++;
    if (fe_cnt != f0 + 1 || dv_cnt != n0) begin
      errors++; $display("FAIL frame_err_strobes: got fe=%0d dv=%0d required 1 0", fe_cnt - f0, dv_cnt - n0);
    end
    checks++;
    if (bus.o_RX_Byte !== last_byte || bus.o_RX_Active !== 1'b1) begin
      errors++;
      $display("FAIL frame_err_hold: got byte=%h act=%b required %h 1", bus.o_RX_Byte, bus.o_RX_Active, last_byte);
    end
    idle(2 * C);
    checks++;
    if (bus.o_RX_Active !== 1'b0 || fe_cnt != f0 + 1) begin
      errors++; $display("FAIL frame_err_release: got act=%b fe=%0d required 0 1", bus.o_RX_Active, fe_cnt - f0);
    end
    exp_q.push_back(8'h11); last_byte = 8'h11;
    send_frame(8'h11, ^8'h11, 1'b1);
    idle(2 * C);
    checks++;
    if (dv_cnt != n0 + 1) begin
      errors++; $display("FAIL frame_err_recover: got dv=%0d required 1", dv_cnt - n0);
    end
  endtask

  task automatic test_back_to_back;
    int n0;
    n0 = dv_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF); last_byte = 8'hFF;
    send_frame(8'h00, ^8'h00, 1'b1);
    send_frame(8'hFF, ^8'hFF, 1'b1);
    idle(2 * C);
    checks++;
    if (dv_cnt != n0 + 2 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_count: got dv=%0d pending=%0d required 2 0", dv_cnt - n0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int n0, f0;
    logic [7:0] d;
    d = 8'h77;
    n0 = dv_cnt; f0 = fe_cnt;
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(d[i]);
    bus.i_RX_Serial = d[4];
    repeat (C / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({bus.o_RX_DV, bus.o_RX_Byte, bus.o_RX_Active, bus.o_RX_Frame_Err} !== 11'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got dv=%b byte=%h act=%b fe=%b required all 0",
               bus.o_RX_DV, bus.o_RX_Byte, bus.o_RX_Active, bus.o_RX_Frame_Err);
    end
    last_byte = 8'h00;
    idle(3 * C);
    checks++;
    if (dv_cnt != n0 || fe_cnt != f0 || bus.o_RX_Active !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_abort: got dv=%0d fe=%0d act=%b required 0 0 0", dv_cnt - n0, fe_cnt - f0, bus.o_RX_Active);
    end
    exp_q.push_back(8'h5A); last_byte = 8'h5A;
    send_frame(8'h5A, ^8'h5A, 1'b1);
    idle(2 * C);
    checks++;
    if (dv_cnt != n0 + 1 || bus.o_RX_Byte !== 8'h5A) begin
      errors++; $display("FAIL mid_reset_next: got dv=%0d byte=%h required 1 5a", dv_cnt - n0, bus.o_RX_Byte);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int n0, p0;
    n0 = dv_cnt; p0 = pe_cnt;
    send_frame(8'h07, 1'b0, 1'b1);
    idle(2 * C);
    checks++;
    if (pe_cnt != p0 + 1 || dv_cnt != n0 || bus.o_RX_Byte !== last_byte) begin
      errors++;
      $display("FAIL parity_bad: got pe=%0d dv=%0d byte=%h required 1 0 %h", pe_cnt - p0, dv_cnt - n0, bus.o_RX_Byte, last_byte);
    end
    exp_q.push_back(8'h07); last_byte = 8'h07;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2 * C);
    checks++;
    if (pe_cnt != p0 + 1 || dv_cnt != n0 + 1 || bus.o_RX_Byte !== 8'h07) begin
      errors++;
      $display("FAIL parity_good: got pe=%0d dv=%0d byte=%h required 1 1 07", pe_cnt - p0, dv_cnt - n0, bus.o_RX_Byte);
    end
  endtask
`endif

  initial begin
    bus.i_RX_Serial = 1'b1;
    last_byte = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive deserialiser. It is the receiving end of the 8N1 serial link that the uart_tx driver side produces.
- Samples an asynchronous serial line, validates start/stop framing and shifts in 8 data bits, LSB first.
- Presents each received byte with a one-cycle valid strobe.
- Sits beside uart_tx in the loopback bench and in the device datapath.

Parameters:
CLKS_PER_BIT, 87, clk cycles per bit period (10 MHz / 115200). Legal range >= 4.
SYNC_STAGES, 2, flops in the input synchroniser. Legal range >= 2.

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
i_RX_Serial  input  1  asynchronous serial line, idle high
o_RX_DV  output  1  one-cycle strobe: o_RX_Byte holds a new valid byte
o_RX_Byte  output  8  last correctly received byte
o_RX_Active  output  1  high while a frame is being received (any state except IDLE)
o_RX_Frame_Err  output  1  one-cycle strobe: stop bit sampled low

Behaviour:
- Interface decision: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: o_RX_DV=0, o_RX_Byte=8'h00, o_RX_Active=0, o_RX_Frame_Err=0. Synchroniser flops reset to 1. State=IDLE, counters=0.
- Reset mid-frame aborts the frame with no strobes. The FSM is in IDLE on the cycle after rst is deasserted.
- i_RX_Serial passes through SYNC_STAGES flops. All decisions below use the synchronised bit rx_s.
- Counters:
  - clk_cnt, width $clog2(CLKS_PER_BIT). Cleared on every state change.
  - bit_idx, 3 bits.
- IDLE: when rx_s==0, go to START.
- START: count to (CLKS_PER_BIT-1)/2 (integer division).
  - At that count, if rx_s==0, go to DATA (this is mid start bit).
  - Otherwise the low pulse was a glitch: go to IDLE with no strobe.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into o_RX_Byte shift register position bit_idx.
  - o_RX_Byte itself updates only on success; a separate shift register holds the partial byte.
  - After bit_idx==7 is sampled, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - Sample 1: load the shift register into o_RX_Byte, pulse o_RX_DV on the next cycle, go to IDLE. Back-to-back frames are supported because the next start edge can be detected from mid stop bit.
  - Sample 0: pulse o_RX_Frame_Err, leave o_RX_Byte unchanged, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. This prevents a held-low line from being parsed as repeated frames.
- Latency: o_RX_DV rises 1 cycle after the stop-bit sample. That is roughly 9.5*CLKS_PER_BIT + SYNC_STAGES + 1 cycles after the start falling edge at the pin.
- o_RX_DV and o_RX_Frame_Err are never high together. Each is high for exactly one cycle per frame.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. It samples one even-parity bit after CLKS_PER_BIT cycles.
  - Extra output o_RX_Parity_Err, 1 bit, reset 0.
  - On mismatch: o_RX_Parity_Err pulses in the same cycle that o_RX_DV would have, o_RX_DV is suppressed, and o_RX_Byte is unchanged.
  - Framing is still checked. If both parity and stop bit fail, only o_RX_Frame_Err is reported.
- Undefined: 8N1 only. No PARITY state and no o_RX_Parity_Err port.

Decomposition:
- Shared package uart_pkg:
  - enum rx_state_t {IDLE, START, DATA, PARITY, STOP, BREAK}.
  - Constant DATA_BITS=8.
  - Function half_bit(CLKS_PER_BIT).
  - The same package serves uart_tx.
- One sub-module, uart_sync: a parameterised SYNC_STAGES flop chain with a reset value of 1.

Test Plan:
- CLKS_PER_BIT=8, drive 0xA5 as 8N1 -> one o_RX_DV pulse, o_RX_Byte=8'hA5, DV at 76+SYNC_STAGES+1 cycles after the start edge, o_RX_Active low afterwards.
- Low glitch of 3 clocks on an idle line (CLKS_PER_BIT=8) -> returns to IDLE, no o_RX_DV, no o_RX_Frame_Err, o_RX_Byte unchanged.
- Drive 0x3C with the stop bit low, then hold the line low for 20 bit times -> exactly one o_RX_Frame_Err pulse, o_RX_DV=0, o_RX_Byte keeps its prior value, nothing received until the line returns high. A following 0x11 is received correctly.
- Back-to-back 0x00 then 0xFF with a single stop bit and no idle gap -> two o_RX_DV pulses, bytes 8'h00 then 8'hFF.
- Assert rst for 1 cycle during data bit 4 of 0x77 -> all outputs 0 on the next cycle, no strobe for the aborted frame. The next frame 0x5A is received correctly.
- With UART_RX_PARITY_EN: 0x07 with parity bit 0 (wrong) -> o_RX_Parity_Err pulse, o_RX_DV=0. 0x07 with parity bit 1 -> o_RX_DV pulse, o_RX_Byte=8'h07.
